// File: rtl/arb_pkg.sv
// Shared types, default sizes and helpers for the register-write arbiter.
// Build option ARB_FIXED_PRIO_EN selects fixed-priority picking.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_DATA_W  = 8;
  localparam int ARB_MAX_REQ = 8;

  function automatic logic [ARB_MAX_REQ-1:0] onehot(
    input logic [2:0] idx
  );
    return ARB_MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrapped first-set search starting at ptr.
// With ARB_FIXED_PRIO_EN the search always starts at index 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  int   j;
  logic found;

  always_comb begin
    j     = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (int'(ptr) + k) % NUM_REQ;
`endif
      if (!found && req[j]) begin
        idx   = ID_W'(j);
        found = 1'b1;
      end
    end
  end

  assign valid = found;

endmodule

// File: rtl/rr_reg_write_arbiter.sv
// Arbitrates NUM_REQ writers onto one shared register, one write per 2 cycles.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module rr_reg_write_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [ID_W-1:0]          owner,
  output logic                     busy,
  output logic [DATA_W-1:0]        Q
);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     win_q, win_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   q_q, q_d;

  logic                pick_valid;
  logic [ID_W-1:0]     pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    ack_d   = '0;
    owner_d = owner_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = NUM_REQ'(onehot(3'(pick_idx)));
          win_d   = pick_idx;
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        // a dropped request aborts without touching Q, owner or ptr
        if (req[win_q]) begin
          q_d     = wdata[int'(win_q)*DATA_W +: DATA_W];
          ack_d   = NUM_REQ'(onehot(3'(win_q)));
          owner_d = win_q;
`ifndef ARB_FIXED_PRIO_EN
          if (int'(win_q) == NUM_REQ-1) ptr_d = '0;
          else                          ptr_d = win_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      owner_q <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign busy  = (state_q == WRITE);
  assign Q     = q_q;

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Self-checking bench for rr_reg_write_arbiter: vector table,
// hand sequences and randomized run against a reference model.
module tb_rr_reg_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic [IW-1:0]   owner;
  logic            busy;
  logic [DW-1:0]   Q;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rr_reg_write_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .owner (owner),
    .busy  (busy),
    .Q     (Q)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic            rst;
    logic [N-1:0]    rq;
    logic [N*DW-1:0] wd;
    logic [N-1:0]    e_gnt;
    logic [N-1:0]    e_ack;
    logic [IW-1:0]   e_own;
    logic            e_busy;
    logic [DW-1:0]   e_q;
  } vec_t;

  // reference model state
  bit           m_busy;
  int           m_win, m_ptr, m_own;
  logic [DW-1:0] m_q;
  logic [N-1:0] m_gnt, m_ack;

  function automatic int pick(input logic [N-1:0] r, input int p);
    int base;
`ifdef ARB_FIXED_PRIO_EN
    base = 0;
`else
    base = p;
`endif
    for (int k = 0; k < N; k++)
      if (r[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_busy = 0; m_win = 0; m_ptr = 0; m_own = 0;
      m_q = '0; m_gnt = '0; m_ack = '0;
    end else if (!m_busy) begin
      m_ack = '0;
      if (req != 0) begin
        m_win  = pick(req, m_ptr);
        m_gnt  = N'(1) << m_win;
        m_busy = 1;
      end else begin
        m_gnt = '0;
      end
    end else begin
      m_gnt  = '0;
      m_busy = 0;
      if (req[m_win]) begin
        m_q   = wdata[m_win*DW +: DW];
        m_ack = N'(1) << m_win;
        m_own = m_win;
`ifndef ARB_FIXED_PRIO_EN
        m_ptr = (m_win + 1) % N;
`endif
      end else begin
        m_ack = '0;
      end
    end
  endtask

  initial begin
    vec_t v[$];
    logic [N*DW-1:0] w_rr, w_a5, w_ff;
    int acks;

    w_rr = {8'h13, 8'h12, 8'h11, 8'h10};
    w_a5 = {8'h13, 8'hA5, 8'h11, 8'h10};
    w_ff = {8'h13, 8'h12, 8'h11, 8'hFF};
    reset = 1'b1;
    req   = '0;
    wdata = '0;

    // reset, single request, reset again
    v.push_back('{1, 4'b1111, w_rr, 4'b0000, 4'b0000, 0, 0, 8'h00});
    v.push_back('{1, 4'b1111, w_rr, 4'b0000, 4'b0000, 0, 0, 8'h00});
    v.push_back('{0, 4'b0100, w_a5, 4'b0100, 4'b0000, 0, 1, 8'h00});
    v.push_back('{0, 4'b0100, w_a5, 4'b0000, 4'b0100, 2, 0, 8'hA5});
    v.push_back('{0, 4'b0000, w_a5, 4'b0000, 4'b0000, 2, 0, 8'hA5});
    v.push_back('{1, 4'b0000, w_rr, 4'b0000, 4'b0000, 0, 0, 8'h00});
`ifndef ARB_FIXED_PRIO_EN
    // round-robin with all requesting
    v.push_back('{0, 4'b1111, w_rr, 4'b0001, 4'b0000, 0, 1, 8'h00});
    v.push_back('{0, 4'b1111, w_rr, 4'b0000, 4'b0001, 0, 0, 8'h10});
    v.push_back('{0, 4'b1111, w_rr, 4'b0010, 4'b0000, 0, 1, 8'h10});
    v.push_back('{0, 4'b1111, w_rr, 4'b0000, 4'b0010, 1, 0, 8'h11});
    v.push_back('{0, 4'b1111, w_rr, 4'b0100, 4'b0000, 1, 1, 8'h11});
    v.push_back('{0, 4'b1111, w_rr, 4'b0000, 4'b0100, 2, 0, 8'h12});
    v.push_back('{0, 4'b1111, w_rr, 4'b1000, 4'b0000, 2, 1, 8'h12});
    v.push_back('{0, 4'b1111, w_rr, 4'b0000, 4'b1000, 3, 0, 8'h13});
    v.push_back('{0, 4'b1111, w_rr, 4'b0001, 4'b0000, 3, 1, 8'h13});
    v.push_back('{0, 4'b1111, w_rr, 4'b0000, 4'b0001, 0, 0, 8'h10});
    // abort keeps ptr at 1
    v.push_back('{0, 4'b0010, w_rr, 4'b0010, 4'b0000, 0, 1, 8'h10});
    v.push_back('{0, 4'b0000, w_rr, 4'b0000, 4'b0000, 0, 0, 8'h10});
    v.push_back('{0, 4'b0011, w_rr, 4'b0010, 4'b0000, 0, 1, 8'h10});
    v.push_back('{0, 4'b0011, w_rr, 4'b0000, 4'b0010, 1, 0, 8'h11});
    // reset during WRITE discards the write
    v.push_back('{0, 4'b0001, w_ff, 4'b0001, 4'b0000, 1, 1, 8'h11});
    v.push_back('{1, 4'b0001, w_ff, 4'b0000, 4'b0000, 0, 0, 8'h00});
    v.push_back('{0, 4'b0000, w_ff, 4'b0000, 4'b0000, 0, 0, 8'h00});
`endif

    for (int i = 0; i < v.size(); i++) begin
      reset = v[i].rst;
      req   = v[i].rq;
      wdata = v[i].wd;
      tick();
      chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(v[i].e_gnt));
      chk($sformatf("vec%0d ack", i), 32'(ack), 32'(v[i].e_ack));
      chk($sformatf("vec%0d owner", i), 32'(owner), 32'(v[i].e_own));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(v[i].e_busy));
      chk($sformatf("vec%0d Q", i), 32'(Q), 32'(v[i].e_q));
    end

    // peak throughput: 4 writes in 8 cycles, gnt/ack exclusive
    reset = 1'b1; req = '0; wdata = w_rr;
    tick();
    reset = 1'b0; req = 4'b1111;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ack != 0) acks++;
      chk("thru excl", 32'(gnt & ack), 32'h0);
    end
    chk("thru acks", 32'(acks), 32'd4);

`ifdef ARB_FIXED_PRIO_EN
    reset = 1'b1; req = '0;
    tick();
    reset = 1'b0; req = 4'b1010;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ack != 0) begin
        acks++;
        chk("fixed ack", 32'(ack), 32'h2);
      end
      chk("fixed no gnt3", 32'(gnt[3]), 32'h0);
    end
    chk("fixed acks", 32'(acks), 32'd4);
`endif

    // randomized run against the reference model
    reset = 1'b1; req = '0;
    model_step();
    tick();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      req   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      wdata = {$urandom};
      model_step();
      tick();
      chk($sformatf("rnd%0d gnt", c), 32'(gnt), 32'(m_gnt));
      chk($sformatf("rnd%0d ack", c), 32'(ack), 32'(m_ack));
      chk($sformatf("rnd%0d owner", c), 32'(owner), 32'(m_own));
      chk($sformatf("rnd%0d busy", c), 32'(busy), 32'(m_busy));
      chk($sformatf("rnd%0d Q", c), 32'(Q), 32'(m_q));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
